// File: rtl/uart_rx_core_fifo_err_if.sv
// Receive-FIFO side of the UART core: the consumer pops characters and reads
// status. Handshake: a pop takes effect on any clk edge where pop_i=1 and empty_o=0.
interface uart_rx_core_fifo_err_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          pop_i;
  logic          fifo_clr;
  logic          ovr_clr;
  logic [CW-1:0] trig_lvl;
  logic [7:0]    data_o;
  logic          pe_o;
  logic          fe_o;
  logic          bi_o;
  logic          empty_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          overrun_o;
  logic          trig_o;
  logic          timeout_o;
  logic          err_in_fifo_o;

  modport master (
    output pop_i, fifo_clr, ovr_clr, trig_lvl,
    input  data_o, pe_o, fe_o, bi_o, empty_o, full_o, count_o,
           overrun_o, trig_o, timeout_o, err_in_fifo_o
  );

  modport slave (
    input  pop_i, fifo_clr, ovr_clr, trig_lvl,
    output data_o, pe_o, fe_o, bi_o, empty_o, full_o, count_o,
           overrun_o, trig_o, timeout_o, err_in_fifo_o
  );
endinterface

// File: rtl/uart_rx_core_fifo_err.sv
// Oversampling UART deserializer feeding a show-ahead FIFO whose entries carry
// {bi, fe, pe, data}, with trigger, character-timeout, overrun and error-present flags.
module uart_rx_core_fifo_err #(
  parameter int FIFO_DEPTH    = 16,
  parameter int OVS           = 16,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_pulse,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  uart_rx_core_fifo_err_if.slave fif,
  output logic [2:0] dbg_state_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TKW = $clog2(OVS);
  localparam int TOW = $clog2(TIMEOUT_CHARS * OVS * 12 + 1);
  localparam logic [TKW-1:0] TICK_FULL = TKW'(OVS - 1);
  localparam logic [TKW-1:0] TICK_HALF = TKW'(OVS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  logic rx_s1_q, rx_s2_q;

  state_t         state_q, state_d;
  logic [TKW-1:0] tick_q, tick_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;

  logic push, push_pe, push_fe, push_bi;
  logic exp_par;
  logic [2:0] bit_last;

  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, err_q, err_d;
  logic          overrun_q, overrun_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  logic          empty, full, pop_ok, push_ok, ovr_set, head_flag, push_flag;
  logic [10:0]   head;
  logic [3:0]    frame_bits;
  logic [TOW-1:0] to_limit;

  // Two-flop synchronizer; idle line level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign bit_last = {1'b0, wls} + 3'd4;
  assign exp_par  = sticky_parity ? ~eps : (eps ? ^shift_q : ~^shift_q);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    push    = 1'b0;
    push_pe = 1'b0;
    push_fe = 1'b0;
    push_bi = 1'b0;
    if (baud_pulse) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s2_q) begin
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
          end
        end
        S_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_FULL) begin
            tick_d          = '0;
            shift_d[bit_q]  = rx_s2_q;
            if (bit_q == bit_last) state_d = pen ? S_PARITY : S_STOP;
            else                   bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == TICK_FULL) begin
            tick_d  = '0;
            par_d   = rx_s2_q;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_FULL) begin
            tick_d  = '0;
            push    = 1'b1;
            push_fe = ~rx_s2_q;
            push_bi = (shift_q == 8'h00) & ~(pen & par_q) & ~rx_s2_q;
            // A break is reported as a pure break entry, never with a parity error.
            push_pe = pen & (par_q != exp_par) & ~push_bi;
            state_d = push_bi ? S_BREAK : S_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s2_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  assign dbg_state_o = state_q;

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign head      = mem[rd_ptr_q];
  assign head_flag = |head[10:8];
  assign push_flag = push_pe | push_fe | push_bi;
  assign pop_ok    = fif.pop_i & ~empty & ~fif.fifo_clr;
  assign push_ok   = push & ~fif.fifo_clr & (~full | pop_ok);
  assign ovr_set   = push & ~fif.fifo_clr & full & ~pop_ok;

  assign frame_bits = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
  assign to_limit   = TOW'(TIMEOUT_CHARS * OVS) * TOW'(frame_bits);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    overrun_d = ovr_set | (overrun_q & ~fif.ovr_clr);
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (fif.fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case ({push_ok & push_flag, pop_ok & head_flag})
        2'b10:   err_d = err_q + 1'b1;
        2'b01:   err_d = err_q - 1'b1;
        default: err_d = err_q;
      endcase
    end
    if (fif.fifo_clr || empty || push_ok || pop_ok) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (baud_pulse && !timeout_q) begin
      to_cnt_d  = to_cnt_q + 1'b1;
      timeout_d = (to_cnt_d >= to_limit);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {push_bi, push_fe, push_pe, shift_q};
  end

  assign fif.data_o        = empty ? 8'h00 : head[7:0];
  assign fif.pe_o          = ~empty & head[8];
  assign fif.fe_o          = ~empty & head[9];
  assign fif.bi_o          = ~empty & head[10];
  assign fif.empty_o       = empty;
  assign fif.full_o        = full;
  assign fif.count_o       = count_q;
  assign fif.overrun_o     = overrun_q;
  assign fif.trig_o        = (fif.trig_lvl != '0) && (count_q >= fif.trig_lvl);
  assign fif.timeout_o     = timeout_q;
  assign fif.err_in_fifo_o = (err_q != '0);
endmodule

// File: tb/tb_uart_rx_core_fifo_err.sv
// Directed bench for uart_rx_core_fifo_err: frames driven bit by bit on rx,
// head entry and status flags compared against hand-computed values.
module tb_uart_rx_core_fifo_err;
  localparam int OVS      = 16;
  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = OVS * 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       baud_pulse = 1'b0;
  logic [1:0] wls = 2'd3;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  uart_rx_core_fifo_err_if #(.FIFO_DEPTH(DEPTH)) fif ();

  uart_rx_core_fifo_err #(.FIFO_DEPTH(DEPTH), .OVS(OVS), .TIMEOUT_CHARS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .baud_pulse    (baud_pulse),
    .wls           (wls),
    .stb           (stb),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .fif           (fif),
    .dbg_state_o   (dbg_state)
  );

  // Clock / baud tick: baud_pulse is high every second clk.
  always #5 clk = ~clk;

  initial begin : baud_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      baud_pulse = (ph % 2 == 0);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic use_par,
                            input logic par, input logic stopv);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (use_par) send_bit(par);
    send_bit(stopv);
    send_bit(1'b1);
  endtask

  task automatic pop_one();
    fif.pop_i = 1'b1;
    wait_clks(1);
    fif.pop_i = 1'b0;
    wait_clks(1);
  endtask

  task automatic pulse_clr(input bit ovr);
    if (ovr) fif.ovr_clr = 1'b1;
    else     fif.fifo_clr = 1'b1;
    wait_clks(1);
    fif.ovr_clr  = 1'b0;
    fif.fifo_clr = 1'b0;
    wait_clks(1);
  endtask

  // Raises pop_i for exactly the cycle of the stop-bit sample (the OVS-th tick in STOP).
  task automatic pop_at_push();
    int  n;
    int  seen;
    bit  done;
    n = 0; seen = 0; done = 0;
    while (!done && n < 4000) begin
      @(negedge clk); #1;
      n++;
      if (dbg_state == 3'd4 && baud_pulse) begin
        seen++;
        if (seen == OVS) begin
          fif.pop_i = 1'b1;
          @(negedge clk); #1;
          fif.pop_i = 1'b0;
          done = 1;
        end
      end
    end
    check("pop_push_sync", 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_b;
    fif.pop_i    = 1'b0;
    fif.fifo_clr = 1'b0;
    fif.ovr_clr  = 1'b0;
    fif.trig_lvl = '0;

    wait_clks(4);
    check("rst_empty",   32'(fif.empty_o), 32'd1);
    check("rst_count",   32'(fif.count_o), 32'd0);
    check("rst_full",    32'(fif.full_o), 32'd0);
    check("rst_overrun", 32'(fif.overrun_o), 32'd0);
    check("rst_timeout", 32'(fif.timeout_o), 32'd0);
    check("rst_err",     32'(fif.err_in_fifo_o), 32'd0);
    check("rst_data",    32'(fif.data_o), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("a5_data",  32'(fif.data_o), 32'hA5);
    check("a5_pe",    32'(fif.pe_o), 32'd0);
    check("a5_fe",    32'(fif.fe_o), 32'd0);
    check("a5_bi",    32'(fif.bi_o), 32'd0);
    check("a5_count", 32'(fif.count_o), 32'd1);
    check("a5_err",   32'(fif.err_in_fifo_o), 32'd0);
    pop_one();
    check("a5_empty", 32'(fif.empty_o), 32'd1);

    // 7E1 0x35: four ones, even parity bit should be 0; sending 1 is a parity error
    wls = 2'd2; pen = 1'b1; eps = 1'b1;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_pe",   32'(fif.pe_o), 32'd1);
    check("7e1_data", 32'(fif.data_o), 32'h35);
    check("7e1_fe",   32'(fif.fe_o), 32'd0);
    check("7e1_err",  32'(fif.err_in_fifo_o), 32'd1);
    pop_one();
    check("7e1_err_pop", 32'(fif.err_in_fifo_o), 32'd0);

    // 5O1 0x13: three ones, odd parity bit 0 is correct
    wls = 2'd0; eps = 1'b0;
    send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1);
    check("5o1_pe",   32'(fif.pe_o), 32'd0);
    check("5o1_data", 32'(fif.data_o), 32'h13);
    pop_one();

    // Break: rx low for three frame times
    wls = 2'd3; pen = 1'b0;
    rx = 1'b0;
    wait_clks(3 * 10 * BIT_CLKS);
    check("brk_count", 32'(fif.count_o), 32'd1);
    check("brk_data",  32'(fif.data_o), 32'h00);
    check("brk_bi",    32'(fif.bi_o), 32'd1);
    check("brk_fe",    32'(fif.fe_o), 32'd1);
    check("brk_pe",    32'(fif.pe_o), 32'd0);
    check("brk_state", 32'(dbg_state), 32'd5);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("brk_count_hi", 32'(fif.count_o), 32'd1);
    check("brk_idle",     32'(dbg_state), 32'd0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    check("brk_next_count", 32'(fif.count_o), 32'd2);
    pop_one();
    check("brk_next_data", 32'(fif.data_o), 32'h3C);
    pop_one();
    check("brk_drained", 32'(fif.empty_o), 32'd1);

    // Overrun: 17 frames into 16 entries
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
    check("ovr_full",    32'(fif.full_o), 32'd1);
    check("ovr_count",   32'(fif.count_o), 32'd16);
    check("ovr_flag",    32'(fif.overrun_o), 32'd1);
    check("ovr_head",    32'(fif.data_o), 32'h01);
    pulse_clr(1'b1);
    check("ovr_cleared", 32'(fif.overrun_o), 32'd0);
    fork
      send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b1);
      pop_at_push();
    join
    check("pp_overrun", 32'(fif.overrun_o), 32'd0);
    check("pp_full",    32'(fif.full_o), 32'd1);
    check("pp_head",    32'(fif.data_o), 32'h02);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 2) : 8'hEE;
      check("drain_data", 32'(fif.data_o), 32'(exp_b));
      pop_one();
    end
    check("drain_empty", 32'(fif.empty_o), 32'd1);

    // Trigger level 4 and character timeout (limit 4*16*10 = 640 ticks)
    fif.trig_lvl = 5'd4;
    for (int i = 0; i < 3; i++) send_frame(8'(8'h40 + i), 8, 1'b0, 1'b0, 1'b1);
    check("trig_3", 32'(fif.trig_o), 32'd0);
    send_frame(8'h43, 8, 1'b0, 1'b0, 1'b1);
    check("trig_4",     32'(fif.trig_o), 32'd1);
    check("trig_count", 32'(fif.count_o), 32'd4);
    wait_clks(590 * 2);
    check("to_early", 32'(fif.timeout_o), 32'd0);
    wait_clks(60 * 2);
    check("to_fire",  32'(fif.timeout_o), 32'd1);
    pop_one();
    check("to_pop",   32'(fif.timeout_o), 32'd0);
    check("trig_pop", 32'(fif.trig_o), 32'd0);
    pulse_clr(1'b0);
    check("clr_empty", 32'(fif.empty_o), 32'd1);
    check("clr_count", 32'(fif.count_o), 32'd0);
    fif.trig_lvl = '0;

    // fifo_clr also drops the error-present indication
    wls = 2'd2; pen = 1'b1; eps = 1'b1;
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
    check("clr_err_before", 32'(fif.err_in_fifo_o), 32'd1);
    pulse_clr(1'b0);
    check("clr_err_after", 32'(fif.err_in_fifo_o), 32'd0);
    check("clr_err_empty", 32'(fif.empty_o), 32'd1);
    wls = 2'd3; pen = 1'b0; eps = 1'b0;

    // 0.4-bit glitch is a false start
    rx = 1'b0;
    wait_clks(13);
    rx = 1'b1;
    wait_clks(12 * BIT_CLKS);
    check("glitch_count", 32'(fif.count_o), 32'd0);
    check("glitch_state", 32'(dbg_state), 32'd0);

    // Reset mid-frame with one entry stored
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check("mid_pre_count", 32'(fif.count_o), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_state_data", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    wait_clks(2);
    check("mid_empty", 32'(fif.empty_o), 32'd1);
    check("mid_count", 32'(fif.count_o), 32'd0);
    check("mid_data",  32'(fif.data_o), 32'd0);
    check("mid_state", 32'(dbg_state), 32'd0);
    rx = 1'b1;
    rst = 1'b1;
    wait_clks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
